// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: FSM state encoding,
// ALU opcodes, the LFSR/MISR feedback polynomial and small helpers.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int unsigned NUM_OPS = 5;

  // Feedback taps shared by both operand generators and the signature register.
  localparam logic [31:0] POLY = 32'h8020_0003;

  // Opcode applied at a given position of the per-vector operation sweep.
  function automatic logic [2:0] op_at(input logic [2:0] idx);
    logic [2:0] op;
    case (idx)
      3'd0:    op = OP_AND;
      3'd1:    op = OP_OR;
      3'd2:    op = OP_ADD;
      3'd3:    op = OP_SUB;
      3'd4:    op = OP_SLT;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // One Galois left-shift step: shift in a zero, fold the polynomial back
  // in when a one falls off the top.
  function automatic logic [31:0] galois_shl(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/alu_bist_lfsr32.sv
// 32-bit Galois shift register used both as an operand generator (xor_i
// tied to zero) and as the response compactor (xor_i = captured response).
module lfsr32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  input  logic [31:0] xor_i,
  output logic [31:0] state_o
);
  import alu_bist_pkg::*;

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Load wins over step so a restart never mixes in a stale step.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = galois_shl(state_q) ^ xor_i;
    end
  end

  // State register; reset clears it so the signature reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/alu_bist.sv
// ALU self-test controller: sweeps pseudo-random operand pairs through the
// five ALU operations and compacts every response into a MISR signature.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start, ALU inputs released
// ST_APPLY   | operands and opcode driven, ALU settling
// ST_CAPTURE | operands held, ALU response folded into the MISR
// ST_DONE    | run finished, signature and pass held until restart
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  ALUControl,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic        C_out,
  output logic        test_mode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);
  import alu_bist_pkg::*;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  LAST_OP  = 3'(NUM_OPS - 1);

  state_e      state_q;
  logic [2:0]  op_idx_q;
  logic [15:0] vec_cnt_q;

  logic        active;
  logic        launch;
  logic        last_op;
  logic        more_vecs;
  logic        lfsr_step;
  logic        misr_step;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;
  logic [31:0] misr_q;
  logic [31:0] misr_in;

  assign active    = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
  // Start is only honoured when no run is in flight.
  assign launch    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_op   = (op_idx_q == LAST_OP);
  assign more_vecs = (vec_cnt_q < LAST_VEC);
  // Operands advance only after the last operation of a vector is captured.
  assign lfsr_step = (state_q == ST_CAPTURE) && last_op && more_vecs;
  assign misr_step = (state_q == ST_CAPTURE);
  assign misr_in   = ALUResult ^ {30'd0, C_out, Zero};

  lfsr32 u_gen_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (launch),
    .seed_i  (LFSR_SEED),
    .step_i  (lfsr_step),
    .xor_i   (32'h0000_0000),
    .state_o (lfsr_a)
  );

  lfsr32 u_gen_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (launch),
    .seed_i  (~LFSR_SEED),
    .step_i  (lfsr_step),
    .xor_i   (32'h0000_0000),
    .state_o (lfsr_b)
  );

  lfsr32 u_misr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (launch),
    .seed_i  (32'h0000_0000),
    .step_i  (misr_step),
    .xor_i   (misr_in),
    .state_o (misr_q)
  );

  // Sequencer: op index walks the op table, vector counter walks the pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_idx_q  <= 3'd0;
      vec_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_APPLY;
            op_idx_q  <= 3'd0;
            vec_cnt_q <= 16'd0;
          end
        end
        ST_APPLY: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!last_op) begin
            op_idx_q <= op_idx_q + 3'd1;
            state_q  <= ST_APPLY;
          end else if (more_vecs) begin
            op_idx_q  <= 3'd0;
            vec_cnt_q <= vec_cnt_q + 16'd1;
            state_q   <= ST_APPLY;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ALUControl = active ? op_at(op_idx_q) : 3'b000;
  assign SrcA       = active ? lfsr_a : 32'h0000_0000;
  assign SrcB       = active ? lfsr_b : 32'h0000_0000;
  assign test_mode  = active;
  assign busy       = active;
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (misr_q == GOLDEN_SIG);
  assign signature  = misr_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: three instances (single vector, default
// length, short run against a faulty ALU) checked against a behavioural
// signature model.
module tb_alu_bist;

  localparam logic [31:0] SEED    = 32'hACE1_2468;
  localparam logic [31:0] POLY_TB = 32'h8020_0003;

  function automatic logic [31:0] shl(input logic [31:0] x);
    logic [31:0] r;
    r = x << 1;
    if (x[31]) r = r ^ POLY_TB;
    return r;
  endfunction

  function automatic logic [2:0] op_code(input int k);
    logic [2:0] op;
    case (k)
      0:       op = 3'b000;
      1:       op = 3'b001;
      2:       op = 3'b010;
      3:       op = 3'b110;
      default: op = 3'b111;
    endcase
    return op;
  endfunction

  // Reference ALU: {result, carry, zero}; stuck forces result bit 0 low on the bus.
  function automatic logic [33:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic stuck);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c;
    sum = 33'd0;
    r   = 32'd0;
    c   = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[31:0];
        c   = sum[32];
      end
      3'b110: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r   = sum[31:0];
        c   = sum[32];
      end
      3'b111: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r   = {31'd0, ($signed(a) < $signed(b))};
        c   = sum[32];
      end
      default: r = 32'd0;
    endcase
    return {(stuck ? (r & 32'hFFFF_FFFE) : r), c, (r == 32'd0)};
  endfunction

  // Expected signature after n operand pairs.
  function automatic logic [31:0] model_sig(input int n, input logic [31:0] seed,
                                            input logic stuck);
    logic [31:0] a, b, m;
    logic [33:0] o;
    a = seed;
    b = ~seed;
    m = 32'd0;
    for (int v = 0; v < n; v++) begin
      for (int k = 0; k < 5; k++) begin
        o = alu_ref(op_code(k), a, b, stuck);
        m = shl(m) ^ o[33:2] ^ {30'd0, o[1:0]};
      end
      a = shl(a);
      b = shl(b);
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD_N1  = model_sig(1, SEED, 1'b0);
  localparam logic [31:0] GOLD_DEF = model_sig(256, SEED, 1'b0);
  localparam logic [31:0] GOLD_F4  = model_sig(4, SEED, 1'b0);

  logic clk = 1'b0;
  logic reset;
  logic start_n1, start_def, start_flt;

  logic [2:0]  ctrl_n1, ctrl_def, ctrl_flt;
  logic [31:0] a_n1, a_def, a_flt, b_n1, b_def, b_flt;
  logic [31:0] sig_n1, sig_def, sig_flt;
  logic        tm_n1, tm_def, tm_flt, busy_n1, busy_def, busy_flt;
  logic        done_n1, done_def, done_flt, pass_n1, pass_def, pass_flt;
  logic [33:0] alu_n1, alu_def, alu_flt;

  assign alu_n1  = alu_ref(ctrl_n1, a_n1, b_n1, 1'b0);
  assign alu_def = alu_ref(ctrl_def, a_def, b_def, 1'b0);
  assign alu_flt = alu_ref(ctrl_flt, a_flt, b_flt, 1'b1);

  always #5 clk = ~clk;

  alu_bist #(.NUM_VECTORS(1), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_N1)) u_n1 (
    .clk(clk), .reset(reset), .start(start_n1), .ALUControl(ctrl_n1), .SrcA(a_n1), .SrcB(b_n1),
    .ALUResult(alu_n1[33:2]), .Zero(alu_n1[0]), .C_out(alu_n1[1]), .test_mode(tm_n1),
    .busy(busy_n1), .done(done_n1), .pass(pass_n1), .signature(sig_n1));

  alu_bist #(.GOLDEN_SIG(GOLD_DEF)) u_def (
    .clk(clk), .reset(reset), .start(start_def), .ALUControl(ctrl_def), .SrcA(a_def), .SrcB(b_def),
    .ALUResult(alu_def[33:2]), .Zero(alu_def[0]), .C_out(alu_def[1]), .test_mode(tm_def),
    .busy(busy_def), .done(done_def), .pass(pass_def), .signature(sig_def));

  alu_bist #(.NUM_VECTORS(4), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_F4)) u_flt (
    .clk(clk), .reset(reset), .start(start_flt), .ALUControl(ctrl_flt), .SrcA(a_flt), .SrcB(b_flt),
    .ALUResult(alu_flt[33:2]), .Zero(alu_flt[0]), .C_out(alu_flt[1]), .test_mode(tm_flt),
    .busy(busy_flt), .done(done_flt), .pass(pass_flt), .signature(sig_flt));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] ctrl;
    logic       busy;
    logic       done;
  } step_t;
  step_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch a default-length run; cyc = edges from the start-sampling edge to done.
  task automatic run_def(input bit spam, output int cyc);
    start_def = 1'b1;
    tick();
    cyc = 0;
    check("def_launch_busy", 128'(busy_def), 128'(1'b1));
    check("def_launch_done_clr", 128'({done_def, pass_def}), 128'(2'b00));
    start_def = spam;
    while (!done_def && cyc < 3000) begin
      tick();
      cyc++;
    end
    start_def = 1'b0;
    check("def_done_seen", 128'(done_def), 128'(1'b1));
  endtask

  task automatic check_def_cleared(input string name);
    check(name, 128'({busy_def, tm_def, done_def, pass_def, ctrl_def, sig_def, a_def, b_def}),
          128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int cyc;
    int rcyc;

    tbl[0]  = '{3'b000, 1'b1, 1'b0};
    tbl[1]  = '{3'b000, 1'b1, 1'b0};
    tbl[2]  = '{3'b001, 1'b1, 1'b0};
    tbl[3]  = '{3'b001, 1'b1, 1'b0};
    tbl[4]  = '{3'b010, 1'b1, 1'b0};
    tbl[5]  = '{3'b010, 1'b1, 1'b0};
    tbl[6]  = '{3'b110, 1'b1, 1'b0};
    tbl[7]  = '{3'b110, 1'b1, 1'b0};
    tbl[8]  = '{3'b111, 1'b1, 1'b0};
    tbl[9]  = '{3'b111, 1'b1, 1'b0};
    tbl[10] = '{3'b000, 1'b0, 1'b1};

    // Reset held 3 cycles with start asserted throughout: no run may begin.
    reset = 1'b1; start_n1 = 1'b1; start_def = 1'b1; start_flt = 1'b1;
    repeat (3) tick();
    reset = 1'b0; start_n1 = 1'b0; start_def = 1'b0; start_flt = 1'b0;
    tick();
    check_def_cleared("rst_def_outputs");
    check("rst_n1_outputs", 128'({busy_n1, tm_n1, done_n1, pass_n1, ctrl_n1, sig_n1, a_n1, b_n1}),
          128'(0));
    check("rst_flt_outputs", 128'({busy_flt, tm_flt, done_flt, pass_flt, sig_flt}), 128'(0));
    tick();
    check("rst_still_idle", 128'({busy_n1, busy_def, busy_flt}), 128'(0));

    // Single-vector run, cycle by cycle against the table.
    start_n1 = 1'b1;
    tick();
    start_n1 = 1'b0;
    for (int j = 0; j < 11; j++) begin
      check($sformatf("n1_ctrl_%0d", j), 128'(ctrl_n1), 128'(tbl[j].ctrl));
      check($sformatf("n1_busy_%0d", j), 128'({busy_n1, tm_n1}), 128'({tbl[j].busy, tbl[j].busy}));
      check($sformatf("n1_done_%0d", j), 128'(done_n1), 128'(tbl[j].done));
      if (tbl[j].busy) begin
        check($sformatf("n1_ops_%0d", j), 128'({a_n1, b_n1}), 128'({32'hACE1_2468, 32'h531E_DB97}));
      end else begin
        check($sformatf("n1_ops_%0d", j), 128'({a_n1, b_n1}), 128'(0));
      end
      if (j < 10) tick();
    end
    check("n1_signature", 128'(sig_n1), 128'(model_sig(1, SEED, 1'b0)));
    check("n1_pass", 128'(pass_n1), 128'(1'b1));

    // Default-length run after a random idle gap.
    repeat ($urandom_range(0, 6)) tick();
    run_def(1'b0, cyc);
    check("def_latency", 128'(cyc), 128'(2560));
    check("def_signature", 128'(sig_def), 128'(model_sig(256, SEED, 1'b0)));
    check("def_pass", 128'(pass_def), 128'(1'b1));
    repeat ($urandom_range(1, 5)) tick();
    check("def_done_held", 128'({done_def, pass_def, busy_def}), 128'(3'b110));

    // Restart from DONE reproduces the same signature.
    run_def(1'b0, cyc);
    check("def_rerun_latency", 128'(cyc), 128'(2560));
    check("def_rerun_signature", 128'(sig_def), 128'(model_sig(256, SEED, 1'b0)));
    check("def_rerun_pass", 128'(pass_def), 128'(1'b1));

    // Reset on cycle 7 of a run.
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    repeat (6) tick();
    check("midrun_busy_before_reset", 128'(busy_def), 128'(1'b1));
    reset = 1'b1;
    start_def = 1'b1;
    tick();
    reset = 1'b0;
    start_def = 1'b0;
    check_def_cleared("midrun_reset_cleared");
    run_def(1'b0, cyc);
    check("post_reset_latency", 128'(cyc), 128'(2560));
    check("post_reset_signature", 128'(sig_def), 128'(model_sig(256, SEED, 1'b0)));

    // Reset at a random point of a run.
    rcyc = int'($urandom_range(1, 2500));
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    repeat (rcyc) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_def_cleared("rand_reset_cleared");
    tick();
    check_def_cleared("rand_reset_stays_idle");

    // Start held high every cycle of the run: ignored while busy.
    run_def(1'b1, cyc);
    check("spam_latency", 128'(cyc), 128'(2560));
    check("spam_signature", 128'(sig_def), 128'(model_sig(256, SEED, 1'b0)));
    check("spam_pass", 128'(pass_def), 128'(1'b1));

    // Faulty ALU (result bit 0 stuck low).
    start_flt = 1'b1;
    tick();
    start_flt = 1'b0;
    check("flt_busy", 128'({busy_flt, tm_flt}), 128'(2'b11));
    cyc = 0;
    while (!done_flt && cyc < 200) begin
      tick();
      cyc++;
    end
    check("flt_done", 128'(done_flt), 128'(1'b1));
    check("flt_latency", 128'(cyc), 128'(40));
    check("flt_pass", 128'(pass_flt), 128'(1'b0));
    check("flt_signature", 128'(sig_flt), 128'(model_sig(4, SEED, 1'b1)));
    check("flt_sig_differs", 128'(sig_flt != GOLD_F4), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
